life_engine: RTL and testbench
==============================

Name: life_engine

Overview:
- Parametrised Game of Life generation engine: computes one generation of a ROWS x COLS board per start request.
- Successor to the fixed 16x16 single-pass update: configurable dimensions, edge mode and birth/survive rule.
- Processes one row per clock and reports per-run birth/death statistics.
- Sits between the board-state register (display/seed logic) and the generation controller, which issues start and waits for done.

Parameters:
- ROWS, 16, board height (>=3)
- COLS, 16, board width (>=3)
- WRAP, 0, 0 = cells outside the board are dead; 1 = toroidal wrap in both axes
- BIRTH_MASK, 9'b000001000, bit n set: dead cell with n live neighbours is born (B3)
- SURVIVE_MASK, 9'b000001100, bit n set: live cell with n live neighbours survives (S23)
- CNT_W, 32, width of the statistics counters

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- start  in  1  request one generation; sampled only in IDLE
- clear_cnt  in  1  synchronous clear of birth_cnt, death_cnt, gen_cnt
- board_in  in  ROWS*COLS  current board; cell (r,c) = bit r*COLS+c
- busy  out  1  high from the edge accepting start until the edge raising done
- done  out  1  one-cycle pulse; board_out and counters are valid
- board_out  out  ROWS*COLS  next-generation board
- still  out  1  board_out == snapshot of board_in for the last generation
- birth_cnt  out  CNT_W  cumulative births, saturating
- death_cnt  out  CNT_W  cumulative deaths, saturating
- gen_cnt  out  CNT_W  generations completed, saturating

Behaviour:
- Reset (reset=0, asynchronous): state IDLE; busy, done, still = 0; board_out, all counters, internal snapshot/next/row index = 0.
- FSM states:
  - IDLE: start=1 -> snapshot board_in, row_idx=0, busy=1, go to CALC.
  - CALC: each edge registers next-row(row_idx) into next[row_idx] and adds that row's births/deaths to per-run accumulators. row_idx==ROWS-1 -> go to DONE, else row_idx+1.
  - DONE: board_out<=next, still<=(next==snapshot), cumulative counters += per-run values (saturating), gen_cnt+1, done<=1, busy<=0, go to IDLE.
- Latency: start sampled at edge E0; done high during the cycle after edge E(ROWS+1). Default parameters give 17 cycles.
- Throughput: start may be asserted during the done cycle and is accepted, giving back-to-back generations every ROWS+2 cycles.
- start while busy is ignored and not queued.
- board_in is used only at the snapshot; changes during CALC have no effect.
- Neighbour count 0..8 (4 bits) over the 8 neighbours.
  - WRAP=0: out-of-range rows/cols contribute 0.
  - WRAP=1: row -1 maps to ROWS-1, row ROWS maps to 0; same for columns.
- Next state: live -> SURVIVE_MASK[n]; dead -> BIRTH_MASK[n].
- Birth = dead->live; death = live->dead. Per-row counts are log2(COLS)+1 bits; per-run accumulators are log2(ROWS*COLS)+1 bits.
- Saturation: each cumulative counter clamps at 2^CNT_W-1.
- clear_cnt:
  - Outside DONE: zeros the cumulative counters next edge.
  - Coinciding with DONE: clear wins; counters = 0 after that edge and this run's statistics are discarded.
  - board_out is unaffected by clear_cnt.
- Reset mid-run aborts immediately; no done pulse is produced.

Decomposition:
- Shared package life_pkg:
  - FSM state typedef (IDLE, CALC, DONE)
  - default B3/S23 mask constants
  - neighbour-count width constant
- Sub-module life_row_eval, combinational: inputs are the three rows (above, current, below, already wrap/zero-resolved by the parent) plus the rule masks; outputs are the next row, birth count and death count.
- life_engine holds the FSM, row index, snapshot/next registers and counters.

Test Plan:
- Blinker, 16x16, WRAP=0: cells (7,6),(7,7),(7,8), start -> done 17 cycles later; board_out = (6,7),(7,7),(8,7); birth_cnt=2, death_cnt=2, gen_cnt=1, still=0.
- Block still life: (4,4),(4,5),(5,4),(5,5) -> board_out == board_in, still=1, birth/death unchanged. Assert clear_cnt then run again -> counters 0 then gen_cnt=1.
- Corner cells (0,0),(0,15),(15,0), two runs:
  - WRAP=0: empty board, deaths=3, births=0.
  - WRAP=1: (15,15) born and originals survive (2 neighbours each), births=1, deaths=0.
- Glider with WRAP=1, 4 back-to-back starts (start held high through done) -> pattern shifted (+1,+1) mod 16; gen_cnt=4; done every 18 cycles.
- CNT_W=4, blinker run 10 times -> birth_cnt=15 and death_cnt=15 saturated; gen_cnt=10.
- Control checks:
  - start pulsed during CALC -> ignored; exactly one done.
  - reset low at cycle 5 of a run -> busy=0, board_out=0, all counters 0, no done pulse.

Source files
------------

// File: rtl/life_pkg.sv
// Shared definitions for the Game of Life generation engine.
//   state_t      : engine FSM states
//   B3_MASK      : default birth rule (dead cell with exactly 3 neighbours)
//   S23_MASK     : default survive rule (live cell with 2 or 3 neighbours)
//   NBR_W        : width of a neighbour count (0..8)
//   count8()     : number of set bits in an 8-bit neighbourhood
package life_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [8:0] B3_MASK  = 9'b000001000;
  localparam logic [8:0] S23_MASK = 9'b000001100;
  localparam int         NBR_W    = 4;

  function automatic logic [NBR_W-1:0] count8(input logic [7:0] v);
    logic [NBR_W-1:0] s;
    s = '0;
    for (int i = 0; i < 8; i++) begin
      s = s + {{(NBR_W-1){1'b0}}, v[i]};
    end
    return s;
  endfunction

endpackage

// File: rtl/life_row_eval.sv
// Combinational next-state evaluation of one board row.
//   row_up / row_cur / row_dn : the row above, the row itself and the row
//                               below; vertical edge handling is already
//                               resolved by the caller
//   birth_mask / survive_mask : rule masks, bit n = outcome for n neighbours
//   row_next                  : next-generation row
//   births / deaths           : dead->live and live->dead cells in this row
// Horizontal edge handling (dead border or wrap) is done here via WRAP.
module life_row_eval
  import life_pkg::*;
#(
  parameter int COLS = 16,
  parameter int WRAP = 0,
  parameter int CW   = $clog2(COLS) + 1
) (
  input  logic [COLS-1:0] row_up,
  input  logic [COLS-1:0] row_cur,
  input  logic [COLS-1:0] row_dn,
  input  logic [8:0]      birth_mask,
  input  logic [8:0]      survive_mask,
  output logic [COLS-1:0] row_next,
  output logic [CW-1:0]   births,
  output logic [CW-1:0]   deaths
);

  logic [COLS-1:0] born;
  logic [COLS-1:0] died;

  for (genvar c = 0; c < COLS; c++) begin : g_col
    logic [2:0]       lcol;
    logic [2:0]       rcol;
    logic [NBR_W-1:0] nbr;

    // Column -1 / COLS either wraps to the far edge or reads as dead.
    if (WRAP != 0 || c > 0) begin : g_left
      assign lcol = {row_up[(c+COLS-1)%COLS], row_cur[(c+COLS-1)%COLS], row_dn[(c+COLS-1)%COLS]};
    end else begin : g_left_dead
      assign lcol = '0;
    end

    if (WRAP != 0 || c < COLS-1) begin : g_right
      assign rcol = {row_up[(c+1)%COLS], row_cur[(c+1)%COLS], row_dn[(c+1)%COLS]};
    end else begin : g_right_dead
      assign rcol = '0;
    end

    assign nbr         = count8({lcol, rcol, row_up[c], row_dn[c]});
    assign row_next[c] = row_cur[c] ? survive_mask[nbr] : birth_mask[nbr];
    assign born[c]     = ~row_cur[c] &  row_next[c];
    assign died[c]     =  row_cur[c] & ~row_next[c];
  end

  always_comb begin
    births = '0;
    deaths = '0;
    for (int c = 0; c < COLS; c++) begin
      births = births + CW'(born[c]);
      deaths = deaths + CW'(died[c]);
    end
  end

endmodule

// File: rtl/life_engine.sv
// Game of Life generation engine: one generation of a ROWS x COLS board per
// start request, evaluated one row per clock from a snapshot of board_in.
//   clk, reset (async, active-low)
//   start      : request a generation, accepted only when idle
//   clear_cnt  : synchronous clear of the cumulative statistics
//   board_in   : current board, cell (r,c) = bit r*COLS+c
//   busy       : generation in progress
//   done       : one-cycle pulse, board_out / still / counters updated
//   board_out  : next-generation board
//   still      : last generation left the board unchanged
//   birth_cnt, death_cnt, gen_cnt : saturating cumulative statistics
module life_engine
  import life_pkg::*;
#(
  parameter int         ROWS         = 16,
  parameter int         COLS         = 16,
  parameter int         WRAP         = 0,
  parameter logic [8:0] BIRTH_MASK   = B3_MASK,
  parameter logic [8:0] SURVIVE_MASK = S23_MASK,
  parameter int         CNT_W        = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 clear_cnt,
  input  logic [ROWS*COLS-1:0] board_in,
  output logic                 busy,
  output logic                 done,
  output logic [ROWS*COLS-1:0] board_out,
  output logic                 still,
  output logic [CNT_W-1:0]     birth_cnt,
  output logic [CNT_W-1:0]     death_cnt,
  output logic [CNT_W-1:0]     gen_cnt
);

  localparam int ROW_CNT_W = $clog2(COLS) + 1;
  localparam int RUN_W     = $clog2(ROWS*COLS) + 1;
  localparam int RIDX_W    = $clog2(ROWS);
  localparam int SUM_W     = ((CNT_W > RUN_W) ? CNT_W : RUN_W) + 1;

  // Add a per-run amount to a cumulative counter, clamping at all-ones.
  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [RUN_W-1:0] b);
    logic [SUM_W-1:0] s;
    s = SUM_W'(a) + SUM_W'(b);
    if (s > SUM_W'({CNT_W{1'b1}})) sat_add = '1;
    else                           sat_add = s[CNT_W-1:0];
  endfunction

  state_t                         state_q, state_d;
  logic [RIDX_W-1:0]              row_idx_q, row_idx_d;
  logic [ROWS-1:0][COLS-1:0]      snap_q, snap_d;
  logic [ROWS-1:0][COLS-1:0]      next_q, next_d;
  logic [ROWS-1:0][COLS-1:0]      board_out_q, board_out_d;
  logic                           busy_q, busy_d;
  logic                           done_q, done_d;
  logic                           still_q, still_d;
  logic [RUN_W-1:0]               run_birth_q, run_birth_d;
  logic [RUN_W-1:0]               run_death_q, run_death_d;
  logic [CNT_W-1:0]               birth_cnt_q, birth_cnt_d;
  logic [CNT_W-1:0]               death_cnt_q, death_cnt_d;
  logic [CNT_W-1:0]               gen_cnt_q, gen_cnt_d;

  logic [COLS-1:0]                row_up, row_dn, row_next;
  logic [ROW_CNT_W-1:0]           row_births, row_deaths;

  // Vertical neighbours of the row being evaluated; off-board rows wrap or
  // read as dead depending on WRAP.
  always_comb begin
    row_up = '0;
    row_dn = '0;
    if (row_idx_q != '0)         row_up = snap_q[row_idx_q - RIDX_W'(1)];
    else if (WRAP != 0)          row_up = snap_q[ROWS-1];
    if (row_idx_q != RIDX_W'(ROWS-1)) row_dn = snap_q[row_idx_q + RIDX_W'(1)];
    else if (WRAP != 0)          row_dn = snap_q[0];
  end

  life_row_eval #(
    .COLS (COLS),
    .WRAP (WRAP),
    .CW   (ROW_CNT_W)
  ) u_row_eval (
    .row_up       (row_up),
    .row_cur      (snap_q[row_idx_q]),
    .row_dn       (row_dn),
    .birth_mask   (BIRTH_MASK),
    .survive_mask (SURVIVE_MASK),
    .row_next     (row_next),
    .births       (row_births),
    .deaths       (row_deaths)
  );

  always_comb begin
    state_d     = state_q;
    row_idx_d   = row_idx_q;
    snap_d      = snap_q;
    next_d      = next_q;
    board_out_d = board_out_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    still_d     = still_q;
    run_birth_d = run_birth_q;
    run_death_d = run_death_q;
    birth_cnt_d = birth_cnt_q;
    death_cnt_d = death_cnt_q;
    gen_cnt_d   = gen_cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          snap_d      = board_in;
          row_idx_d   = '0;
          run_birth_d = '0;
          run_death_d = '0;
          busy_d      = 1'b1;
          state_d     = ST_CALC;
        end
      end
      ST_CALC: begin
        next_d[row_idx_q] = row_next;
        run_birth_d       = run_birth_q + RUN_W'(row_births);
        run_death_d       = run_death_q + RUN_W'(row_deaths);
        if (row_idx_q == RIDX_W'(ROWS-1)) state_d = ST_DONE;
        else                              row_idx_d = row_idx_q + RIDX_W'(1);
      end
      ST_DONE: begin
        board_out_d = next_q;
        still_d     = (next_q == snap_q);
        birth_cnt_d = sat_add(birth_cnt_q, run_birth_q);
        death_cnt_d = sat_add(death_cnt_q, run_death_q);
        gen_cnt_d   = sat_add(gen_cnt_q, RUN_W'(1));
        done_d      = 1'b1;
        busy_d      = 1'b0;
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // A clear overrides any update, including the one from a finishing run.
    if (clear_cnt) begin
      birth_cnt_d = '0;
      death_cnt_d = '0;
      gen_cnt_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      row_idx_q   <= '0;
      snap_q      <= '0;
      next_q      <= '0;
      board_out_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      still_q     <= 1'b0;
      run_birth_q <= '0;
      run_death_q <= '0;
      birth_cnt_q <= '0;
      death_cnt_q <= '0;
      gen_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      row_idx_q   <= row_idx_d;
      snap_q      <= snap_d;
      next_q      <= next_d;
      board_out_q <= board_out_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      still_q     <= still_d;
      run_birth_q <= run_birth_d;
      run_death_q <= run_death_d;
      birth_cnt_q <= birth_cnt_d;
      death_cnt_q <= death_cnt_d;
      gen_cnt_q   <= gen_cnt_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign board_out = board_out_q;
  assign still     = still_q;
  assign birth_cnt = birth_cnt_q;
  assign death_cnt = death_cnt_q;
  assign gen_cnt   = gen_cnt_q;

endmodule

// File: tb/tb_life_engine.sv
// Bench for life_engine: three instances share the stimulus
//   d0: 16x16, dead border, 32-bit counters
//   d1: 16x16, toroidal,    32-bit counters
//   d2: 16x16, dead border, 4-bit counters
// and are compared against a cell-by-cell Game of Life model.
module tb_life_engine;

  localparam int R = 16;
  localparam int C = 16;
  localparam int N = R * C;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic         clear_cnt;
  logic [N-1:0] board_in;

  logic         ob_busy [3];
  logic         ob_done [3];
  logic         ob_still[3];
  logic [N-1:0] ob_board[3];
  logic [31:0]  ob_birth[3];
  logic [31:0]  ob_death[3];
  logic [31:0]  ob_gen  [3];
  logic [3:0]   c2_birth, c2_death, c2_gen;

  int checks = 0;
  int errors = 0;

  int     wrapv[3] = '{0, 1, 0};
  longint cmax [3] = '{64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'd15};
  logic [N-1:0] exp_board[3];
  logic         exp_still[3];
  longint       exp_birth[3], exp_death[3], exp_gen[3];

  always #5 clk = ~clk;

  life_engine #(.ROWS(R), .COLS(C), .WRAP(0), .BIRTH_MASK(9'b000001000),
                .SURVIVE_MASK(9'b000001100), .CNT_W(32)) u_d0 (
    .clk(clk), .reset(reset), .start(start), .clear_cnt(clear_cnt), .board_in(board_in),
    .busy(ob_busy[0]), .done(ob_done[0]), .board_out(ob_board[0]), .still(ob_still[0]),
    .birth_cnt(ob_birth[0]), .death_cnt(ob_death[0]), .gen_cnt(ob_gen[0]));

  life_engine #(.ROWS(R), .COLS(C), .WRAP(1), .BIRTH_MASK(9'b000001000),
                .SURVIVE_MASK(9'b000001100), .CNT_W(32)) u_d1 (
    .clk(clk), .reset(reset), .start(start), .clear_cnt(clear_cnt), .board_in(board_in),
    .busy(ob_busy[1]), .done(ob_done[1]), .board_out(ob_board[1]), .still(ob_still[1]),
    .birth_cnt(ob_birth[1]), .death_cnt(ob_death[1]), .gen_cnt(ob_gen[1]));

  life_engine #(.ROWS(R), .COLS(C), .WRAP(0), .BIRTH_MASK(9'b000001000),
                .SURVIVE_MASK(9'b000001100), .CNT_W(4)) u_d2 (
    .clk(clk), .reset(reset), .start(start), .clear_cnt(clear_cnt), .board_in(board_in),
    .busy(ob_busy[2]), .done(ob_done[2]), .board_out(ob_board[2]), .still(ob_still[2]),
    .birth_cnt(c2_birth), .death_cnt(c2_death), .gen_cnt(c2_gen));

  assign ob_birth[2] = {28'd0, c2_birth};
  assign ob_death[2] = {28'd0, c2_death};
  assign ob_gen[2]   = {28'd0, c2_gen};

  // ---------------- reference model ----------------
  function automatic logic [N-1:0] put(input logic [N-1:0] b, input int r, input int c);
    logic [N-1:0] t;
    t = b;
    t[((r % R + R) % R) * C + ((c % C + C) % C)] = 1'b1;
    return t;
  endfunction

  function automatic void step(input logic [N-1:0] b, input int wrap,
                               output logic [N-1:0] nb, output int nbir, output int ndea);
    nb = '0; nbir = 0; ndea = 0;
    for (int r = 0; r < R; r++) begin
      for (int c = 0; c < C; c++) begin
        int n;
        bit alive, nxt;
        n = 0;
        for (int dr = -1; dr <= 1; dr++) begin
          for (int dc = -1; dc <= 1; dc++) begin
            int rr, cc;
            rr = r + dr; cc = c + dc;
            if (!(dr == 0 && dc == 0)) begin
              if (wrap != 0) begin rr = (rr + R) % R; cc = (cc + C) % C; end
              if (rr >= 0 && rr < R && cc >= 0 && cc < C) n += int'(b[rr*C+cc]);
            end
          end
        end
        alive = b[r*C+c];
        nxt   = alive ? (n == 2 || n == 3) : (n == 3);
        nb[r*C+c] = nxt;
        if (!alive && nxt) nbir++;
        if (alive && !nxt) ndea++;
      end
    end
  endfunction

  task automatic model_run(input logic [N-1:0] b, input bit clr);
    logic [N-1:0] nb;
    int bi, de;
    for (int i = 0; i < 3; i++) begin
      step(b, wrapv[i], nb, bi, de);
      exp_board[i] = nb;
      exp_still[i] = (nb == b);
      if (clr) begin
        exp_birth[i] = 0; exp_death[i] = 0; exp_gen[i] = 0;
      end else begin
        exp_birth[i] = (exp_birth[i] + bi > cmax[i]) ? cmax[i] : exp_birth[i] + bi;
        exp_death[i] = (exp_death[i] + de > cmax[i]) ? cmax[i] : exp_death[i] + de;
        exp_gen[i]   = (exp_gen[i] + 1 > cmax[i])    ? cmax[i] : exp_gen[i] + 1;
      end
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 3; i++) begin exp_birth[i] = 0; exp_death[i] = 0; exp_gen[i] = 0; end
  endtask

  task automatic model_reset();
    model_clear();
    for (int i = 0; i < 3; i++) begin exp_board[i] = '0; exp_still[i] = 1'b0; end
  endtask

  function automatic logic [N-1:0] rand_board();
    logic [N-1:0] b;
    for (int k = 0; k < N/32; k++) b[k*32 +: 32] = $urandom();
    return b;
  endfunction

  // One generation: start for one cycle, scramble board_in during the run,
  // optionally assert clear_cnt on the finishing edge. Returns edges from
  // the accepting edge to the done edge, and busy right after acceptance.
  task automatic do_run(input logic [N-1:0] b, input bit clr_done,
                        output int lat, output logic busy_e0);
    int cycles;
    @(negedge clk);
    board_in = b; start = 1'b1; cycles = 0; busy_e0 = 1'b0;
    do begin
      @(negedge clk);
      cycles++;
      start = 1'b0;
      if (cycles == 1) busy_e0 = ob_busy[0];
      if (cycles == 3) board_in = ~b;
      if (clr_done && cycles == R + 1) clear_cnt = 1'b1;
    end while (ob_done[0] !== 1'b1 && cycles < 60);
    clear_cnt = 1'b0;
    lat = cycles - 1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b0; start = 1'b0; clear_cnt = 1'b0; board_in = '0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      checks++; if ({ob_busy[i], ob_done[i], ob_still[i]} !== 3'b000) begin errors++;
        $display("FAIL reset ctrl[%0d]: got %b required 000", i, {ob_busy[i], ob_done[i], ob_still[i]}); end
      checks++; if (ob_board[i] !== '0) begin errors++;
        $display("FAIL reset board[%0d]: got %h required 0", i, ob_board[i]); end
      checks++; if ({ob_birth[i], ob_death[i], ob_gen[i]} !== 96'd0) begin errors++;
        $display("FAIL reset cnt[%0d]: got %0d %0d %0d required 0", i, ob_birth[i], ob_death[i], ob_gen[i]); end
    end
    reset = 1'b1;
    model_reset();
  endtask

  task automatic test_blinker();
    logic [N-1:0] b, v;
    int lat; logic bz;
    b = put(put(put('0, 7, 6), 7, 7), 7, 8);
    v = put(put(put('0, 6, 7), 7, 7), 8, 7);
    do_run(b, 1'b0, lat, bz);
    model_run(b, 1'b0);
    checks++; if (lat !== 17) begin errors++; $display("FAIL blinker latency: got %0d required 17", lat); end
    checks++; if (bz !== 1'b1) begin errors++; $display("FAIL blinker busy after start: got %b required 1", bz); end
    checks++; if (ob_busy[0] !== 1'b0) begin errors++; $display("FAIL blinker busy at done: got %b required 0", ob_busy[0]); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (ob_board[i] !== exp_board[i]) begin errors++;
        $display("FAIL blinker board[%0d]: got %h required %h", i, ob_board[i], exp_board[i]); end
      checks++; if ({ob_birth[i], ob_death[i], ob_gen[i]} !== {32'(exp_birth[i]), 32'(exp_death[i]), 32'(exp_gen[i])}) begin errors++;
        $display("FAIL blinker cnt[%0d]: got %0d %0d %0d required %0d %0d %0d", i, ob_birth[i], ob_death[i], ob_gen[i], exp_birth[i], exp_death[i], exp_gen[i]); end
    end
    checks++; if (ob_board[0] !== v) begin errors++; $display("FAIL blinker vertical: got %h required %h", ob_board[0], v); end
    checks++; if ({ob_birth[0], ob_death[0], ob_gen[0], ob_still[0]} !== {32'd2, 32'd2, 32'd1, 1'b0}) begin errors++;
      $display("FAIL blinker stats: got %0d %0d %0d still=%b required 2 2 1 still=0", ob_birth[0], ob_death[0], ob_gen[0], ob_still[0]); end
    @(negedge clk);
    checks++; if (ob_done[0] !== 1'b0) begin errors++; $display("FAIL done pulse width: got %b required 0", ob_done[0]); end
  endtask

  task automatic test_still_block();
    logic [N-1:0] b, bl;
    int lat; logic bz;
    b  = put(put(put(put('0, 4, 4), 4, 5), 5, 4), 5, 5);
    bl = put(put(put('0, 7, 6), 7, 7), 7, 8);
    do_run(b, 1'b0, lat, bz);
    model_run(b, 1'b0);
    for (int i = 0; i < 3; i++) begin
      checks++; if ({ob_board[i], ob_still[i]} !== {exp_board[i], exp_still[i]}) begin errors++;
        $display("FAIL block board[%0d]: got %h still=%b required %h still=%b", i, ob_board[i], ob_still[i], exp_board[i], exp_still[i]); end
      checks++; if ({ob_birth[i], ob_death[i], ob_gen[i]} !== {32'(exp_birth[i]), 32'(exp_death[i]), 32'(exp_gen[i])}) begin errors++;
        $display("FAIL block cnt[%0d]: got %0d %0d %0d required %0d %0d %0d", i, ob_birth[i], ob_death[i], ob_gen[i], exp_birth[i], exp_death[i], exp_gen[i]); end
    end
    checks++; if (ob_still[0] !== 1'b1) begin errors++; $display("FAIL block still: got %b required 1", ob_still[0]); end
    @(negedge clk); clear_cnt = 1'b1;
    @(negedge clk); clear_cnt = 1'b0;
    model_clear();
    for (int i = 0; i < 3; i++) begin
      checks++; if ({ob_birth[i], ob_death[i], ob_gen[i]} !== 96'd0) begin errors++;
        $display("FAIL clear cnt[%0d]: got %0d %0d %0d required 0 0 0", i, ob_birth[i], ob_death[i], ob_gen[i]); end
    end
    do_run(b, 1'b0, lat, bz);
    model_run(b, 1'b0);
    checks++; if (ob_gen[0] !== 32'd1) begin errors++; $display("FAIL gen after clear: got %0d required 1", ob_gen[0]); end
    // Clear coinciding with the finishing edge: statistics dropped, board kept.
    do_run(bl, 1'b1, lat, bz);
    model_run(bl, 1'b1);
    for (int i = 0; i < 3; i++) begin
      checks++; if (ob_board[i] !== exp_board[i]) begin errors++;
        $display("FAIL clear-at-done board[%0d]: got %h required %h", i, ob_board[i], exp_board[i]); end
      checks++; if ({ob_birth[i], ob_death[i], ob_gen[i]} !== 96'd0) begin errors++;
        $display("FAIL clear-at-done cnt[%0d]: got %0d %0d %0d required 0 0 0", i, ob_birth[i], ob_death[i], ob_gen[i]); end
    end
  endtask

  task automatic test_corners();
    logic [N-1:0] b, w;
    int lat; logic bz;
    b = put(put(put('0, 0, 0), 0, 15), 15, 0);
    w = put(b, 15, 15);
    @(negedge clk); clear_cnt = 1'b1;
    @(negedge clk); clear_cnt = 1'b0;
    model_clear();
    do_run(b, 1'b0, lat, bz);
    model_run(b, 1'b0);
    for (int i = 0; i < 3; i++) begin
      checks++; if (ob_board[i] !== exp_board[i]) begin errors++;
        $display("FAIL corners board[%0d]: got %h required %h", i, ob_board[i], exp_board[i]); end
    end
    checks++; if ({ob_board[0], ob_birth[0], ob_death[0]} !== {{N{1'b0}}, 32'd0, 32'd3}) begin errors++;
      $display("FAIL corners dead-edge: births %0d deaths %0d board %h required 0 3 empty", ob_birth[0], ob_death[0], ob_board[0]); end
    checks++; if ({ob_board[1], ob_birth[1], ob_death[1]} !== {w, 32'd1, 32'd0}) begin errors++;
      $display("FAIL corners wrap: births %0d deaths %0d board %h required 1 0 %h", ob_birth[1], ob_death[1], ob_board[1], w); end
  endtask

  task automatic test_random();
    logic [N-1:0] b;
    int lat; logic bz;
    for (int t = 0; t < 5; t++) begin
      b = rand_board();
      do_run(b, 1'b0, lat, bz);
      model_run(b, 1'b0);
      checks++; if (lat !== 17) begin errors++; $display("FAIL random latency %0d: got %0d required 17", t, lat); end
      for (int i = 0; i < 3; i++) begin
        checks++; if ({ob_board[i], ob_still[i]} !== {exp_board[i], exp_still[i]}) begin errors++;
          $display("FAIL random board %0d[%0d]: got %h required %h", t, i, ob_board[i], exp_board[i]); end
        checks++; if ({ob_birth[i], ob_death[i], ob_gen[i]} !== {32'(exp_birth[i]), 32'(exp_death[i]), 32'(exp_gen[i])}) begin errors++;
          $display("FAIL random cnt %0d[%0d]: got %0d %0d %0d required %0d %0d %0d", t, i, ob_birth[i], ob_death[i], ob_gen[i], exp_birth[i], exp_death[i], exp_gen[i]); end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [N-1:0] g, cur, sh;
    int cycles, extra;
    g = '0; sh = '0;
    g  = put(put(put(put(put(g, 14, 15), 15, 16), 16, 14), 16, 15), 16, 16);
    sh = put(put(put(put(put(sh, 15, 16), 16, 17), 17, 15), 17, 16), 17, 17);
    @(negedge clk); clear_cnt = 1'b1;
    @(negedge clk); clear_cnt = 1'b0;
    model_clear();
    board_in = g; start = 1'b1; cur = g;
    for (int gen = 0; gen < 4; gen++) begin
      cycles = 0;
      do begin @(negedge clk); cycles++; end while (ob_done[0] !== 1'b1 && cycles < 60);
      model_run(cur, 1'b0);
      checks++; if (cycles !== 18) begin errors++; $display("FAIL b2b period %0d: got %0d required 18", gen, cycles); end
      for (int i = 0; i < 3; i++) begin
        checks++; if (ob_board[i] !== exp_board[i]) begin errors++;
          $display("FAIL b2b board %0d[%0d]: got %h required %h", gen, i, ob_board[i], exp_board[i]); end
        checks++; if ({ob_birth[i], ob_death[i], ob_gen[i]} !== {32'(exp_birth[i]), 32'(exp_death[i]), 32'(exp_gen[i])}) begin errors++;
          $display("FAIL b2b cnt %0d[%0d]: got %0d %0d %0d required %0d %0d %0d", gen, i, ob_birth[i], ob_death[i], ob_gen[i], exp_birth[i], exp_death[i], exp_gen[i]); end
      end
      cur = exp_board[1];
      board_in = cur;
      if (gen == 3) start = 1'b0;
    end
    checks++; if (ob_board[1] !== sh) begin errors++; $display("FAIL glider shift: got %h required %h", ob_board[1], sh); end
    checks++; if (ob_gen[1] !== 32'd4) begin errors++; $display("FAIL glider gen: got %0d required 4", ob_gen[1]); end
    extra = 0;
    repeat (25) begin @(negedge clk); if (ob_done[0] === 1'b1 || ob_busy[0] === 1'b1) extra++; end
    checks++; if (extra !== 0) begin errors++; $display("FAIL b2b stop: got %0d active cycles required 0", extra); end
  endtask

  task automatic test_start_during_calc();
    logic [N-1:0] b;
    int ndone;
    b = rand_board();
    @(negedge clk); board_in = b; start = 1'b1; ndone = 0;
    for (int k = 1; k <= 45; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
      if (k == 5) begin start = 1'b1; board_in = rand_board(); end
      if (k == 6) start = 1'b0;
      if (ob_done[0] === 1'b1) ndone++;
    end
    model_run(b, 1'b0);
    checks++; if (ndone !== 1) begin errors++; $display("FAIL start-in-calc done count: got %0d required 1", ndone); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (ob_board[i] !== exp_board[i]) begin errors++;
        $display("FAIL start-in-calc board[%0d]: got %h required %h", i, ob_board[i], exp_board[i]); end
      checks++; if ({ob_birth[i], ob_death[i], ob_gen[i]} !== {32'(exp_birth[i]), 32'(exp_death[i]), 32'(exp_gen[i])}) begin errors++;
        $display("FAIL start-in-calc cnt[%0d]: got %0d %0d %0d required %0d %0d %0d", i, ob_birth[i], ob_death[i], ob_gen[i], exp_birth[i], exp_death[i], exp_gen[i]); end
    end
  endtask

  task automatic test_saturation();
    logic [N-1:0] b;
    int lat; logic bz;
    b = put(put(put('0, 7, 6), 7, 7), 7, 8);
    @(negedge clk); clear_cnt = 1'b1;
    @(negedge clk); clear_cnt = 1'b0;
    model_clear();
    for (int t = 0; t < 10; t++) begin
      do_run(b, 1'b0, lat, bz);
      model_run(b, 1'b0);
    end
    for (int i = 0; i < 3; i++) begin
      checks++; if ({ob_birth[i], ob_death[i], ob_gen[i]} !== {32'(exp_birth[i]), 32'(exp_death[i]), 32'(exp_gen[i])}) begin errors++;
        $display("FAIL saturation cnt[%0d]: got %0d %0d %0d required %0d %0d %0d", i, ob_birth[i], ob_death[i], ob_gen[i], exp_birth[i], exp_death[i], exp_gen[i]); end
    end
    checks++; if ({c2_birth, c2_death, c2_gen} !== {4'd15, 4'd15, 4'd10}) begin errors++;
      $display("FAIL saturation 4-bit: got %0d %0d %0d required 15 15 10", c2_birth, c2_death, c2_gen); end
  endtask

  task automatic test_reset_midrun();
    int seen;
    @(negedge clk); board_in = rand_board(); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      checks++; if ({ob_busy[i], ob_done[i], ob_board[i]} !== {2'b00, {N{1'b0}}}) begin errors++;
        $display("FAIL midrun reset[%0d]: busy=%b done=%b board %h required 0", i, ob_busy[i], ob_done[i], ob_board[i]); end
      checks++; if ({ob_birth[i], ob_death[i], ob_gen[i]} !== 96'd0) begin errors++;
        $display("FAIL midrun reset cnt[%0d]: got %0d %0d %0d required 0", i, ob_birth[i], ob_death[i], ob_gen[i]); end
    end
    @(negedge clk); reset = 1'b1;
    model_reset();
    seen = 0;
    repeat (30) begin @(negedge clk); if (ob_done[0] === 1'b1 || ob_done[1] === 1'b1) seen++; end
    checks++; if (seen !== 0) begin errors++; $display("FAIL midrun done after reset: got %0d pulses required 0", seen); end
  endtask

  initial begin
    test_reset();
    test_blinker();
    test_still_block();
    test_corners();
    test_random();
    test_back_to_back();
    test_start_during_calc();
    test_saturation();
    test_reset_midrun();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

endmodule
